winograd_layer_sequencer: RTL and testbench

- Per-layer scheduler for the Winograd F(2x2,3x3) conv datapath.
- For each kernel group it loads the weight set from the weight buffer, then sweeps the feature map in 2-output-row passes.
- For each pass it drives the line-reader controller (start address, bank mux, zero mask, pad) and the write-back controller (output address, conf).
- Raises done after the last write-back of the last group.

---
 rtl/winograd_layer_sequencer_pkg.sv | 20 ++
 rtl/winograd_layer_sequencer_if.sv | 51 +++++
 rtl/wsq_pass_addr_gen.sv | 69 ++++++
 rtl/winograd_layer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_winograd_layer_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/winograd_layer_sequencer_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) layer sequencer.
// No logic: state encoding, lane geometry and reset bank mapping.
package winograd_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_PASS  = 3'd2,
    S_WAIT  = 3'd3,
    S_ADV   = 3'd4,
    S_FIN   = 3'd5
  } seq_state_e;

  localparam int LANES    = 4;
  localparam int ROW_STEP = 2;

  // Lanes 0..3 read banks 0..3 out of reset.
  localparam logic [2*LANES-1:0] BUFMUX_RST = 8'hE4;

endpackage

// File: rtl/winograd_layer_sequencer_if.sv
// Control/config bundle between the layer sequencer and its environment.
// slave = sequencer side, master = environment side (controllers, host).
interface winograd_layer_sequencer_if
  import winograd_layer_sequencer_pkg::*;
#(
  parameter int ADDR_LEN = 9,
  parameter int LINE_W   = 10,
  parameter int GRP_W    = 8
);
  logic                  start;
  logic [LINE_W-1:0]     cfg_linelen;
  logic [LINE_W-1:0]     cfg_rows;
  logic                  cfg_ispad;
  logic [GRP_W-1:0]      cfg_groups;
  logic [ADDR_LEN-1:0]   cfg_in_base;
  logic [ADDR_LEN-1:0]   cfg_out_base;
  logic [ADDR_LEN-1:0]   cfg_out_stride;
  logic [ADDR_LEN-1:0]   cfg_wb_base;
  logic [ADDR_LEN-1:0]   cfg_wb_stride;
  logic                  wb_rd_conf;
  logic [ADDR_LEN-1:0]   wb_st_rd_addr;
  logic                  wb_rd_ready;
  logic                  ilc_start;
  logic [ADDR_LEN-1:0]   ilc_st_addr;
  logic [2*LANES-1:0]    buffermux;
  logic [LANES-1:0]      iszero;
  logic                  ispad;
  logic                  ilc_done;
  logic                  wr_conf;
  logic [ADDR_LEN-1:0]   wr_st_addr;
  logic                  wr_done;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, cfg_linelen, cfg_rows, cfg_ispad, cfg_groups, cfg_in_base,
           cfg_out_base, cfg_out_stride, cfg_wb_base, cfg_wb_stride,
           wb_rd_ready, ilc_done, wr_done,
    output wb_rd_conf, wb_st_rd_addr, ilc_start, ilc_st_addr, buffermux,
           iszero, ispad, wr_conf, wr_st_addr, busy, done
  );

  modport master (
    output start, cfg_linelen, cfg_rows, cfg_ispad, cfg_groups, cfg_in_base,
           cfg_out_base, cfg_out_stride, cfg_wb_base, cfg_wb_stride,
           wb_rd_ready, ilc_done, wr_done,
    input  wb_rd_conf, wb_st_rd_addr, ilc_start, ilc_st_addr, buffermux,
           iszero, ispad, wr_conf, wr_st_addr, busy, done
  );

endinterface

// File: rtl/wsq_pass_addr_gen.sv
// Per-pass line-reader/write-back address, bank mux and zero mask generation.
// Registered on load_i (one cycle), held until the next load; no backpressure.
module wsq_pass_addr_gen
  import winograd_layer_sequencer_pkg::*;
#(
  parameter int ADDR_LEN = 9,
  parameter int LINE_W   = 10,
  parameter int GRP_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [LINE_W-1:0]    pass_i,
  input  logic [GRP_W-1:0]     grp_i,
  input  logic [LINE_W-1:0]    npass_i,
  input  logic [LINE_W-1:0]    rows_i,
  input  logic                 ispad_i,
  input  logic [LINE_W-1:0]    linelen_i,
  input  logic [ADDR_LEN-1:0]  in_base_i,
  input  logic [ADDR_LEN-1:0]  out_base_i,
  input  logic [ADDR_LEN-1:0]  out_stride_i,
  output logic [ADDR_LEN-1:0]  ilc_st_addr_o,
  output logic [2*LANES-1:0]   buffermux_o,
  output logic [LANES-1:0]     iszero_o,
  output logic [ADDR_LEN-1:0]  wr_st_addr_o
);

  localparam int VW   = LINE_W + 2;
  localparam int IDXW = GRP_W + LINE_W;

  logic [VW-1:0]        vrow;
  logic [VW-1:0]        zlim;
  logic [IDXW-1:0]      pass_idx;
  logic [2*LANES-1:0]   mux_d;
  logic [LANES-1:0]     zero_d;
  logic [ADDR_LEN-1:0]  ilc_addr_d;
  logic [ADDR_LEN-1:0]  wr_addr_d;

  always_comb begin
    vrow   = '0;
    mux_d  = '0;
    zero_d = '0;
    // Rows at or beyond H+ispad are the bottom pad or lie past the image.
    zlim   = VW'(rows_i) + VW'(ispad_i);
    for (int l = 0; l < LANES; l++) begin
      vrow             = VW'(pass_i) * VW'(ROW_STEP) + VW'(l);
      mux_d[2*l +: 2]  = vrow[1:0];
      zero_d[l]        = (ispad_i && (vrow == '0)) || (vrow >= zlim);
    end
    pass_idx   = IDXW'(grp_i) * IDXW'(npass_i) + IDXW'(pass_i);
    ilc_addr_d = in_base_i + ADDR_LEN'(pass_i >> 1) * ADDR_LEN'(linelen_i);
    wr_addr_d  = out_base_i + ADDR_LEN'(pass_idx) * out_stride_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ilc_st_addr_o <= '0;
      buffermux_o   <= BUFMUX_RST;
      iszero_o      <= '0;
      wr_st_addr_o  <= '0;
    end else if (load_i) begin
      ilc_st_addr_o <= ilc_addr_d;
      buffermux_o   <= mux_d;
      iszero_o      <= zero_d;
      wr_st_addr_o  <= wr_addr_d;
    end
  end

endmodule

// File: rtl/winograd_layer_sequencer.sv
// Layer scheduler: per kernel group load weights, then run 2-row passes and await both completions.
// All outputs registered; progress stalls on wb_rd_ready, ilc_done and wr_done.
module winograd_layer_sequencer
  import winograd_layer_sequencer_pkg::*;
#(
  parameter int ADDR_LEN = 9,
  parameter int LINE_W   = 10,
  parameter int GRP_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  winograd_layer_sequencer_if.slave   bus
);

  seq_state_e           state_q;
  logic [LINE_W-1:0]    linelen_q;
  logic [LINE_W-1:0]    rows_q;
  logic                 ispad_q;
  logic [GRP_W-1:0]     groups_q;
  logic [ADDR_LEN-1:0]  in_base_q;
  logic [ADDR_LEN-1:0]  out_base_q;
  logic [ADDR_LEN-1:0]  out_stride_q;
  logic [ADDR_LEN-1:0]  wb_stride_q;
  logic [ADDR_LEN-1:0]  wb_addr_q;
  logic [GRP_W-1:0]     g_q;
  logic [LINE_W-1:0]    p_q;
  logic [LINE_W-1:0]    npass_q;
  logic                 calc_p_q;
  logic                 ilc_seen_q;
  logic                 wr_seen_q;
  logic                 wb_rd_conf_q;
  logic                 ilc_start_q;
  logic                 wr_conf_q;
  logic                 busy_q;
  logic                 done_q;

  logic [LINE_W:0]      rows_pad;
  logic [LINE_W-1:0]    npass_calc;
  logic [GRP_W-1:0]     grp_last;
  logic                 more_pass;
  logic                 more_grp;
  logic                 ilc_got;
  logic                 wr_got;
  logic                 load_pass;
  logic [LINE_W-1:0]    pass_d;

  always_comb begin
    // P = ceil((H + 2*ispad - 2)/2), never below one pass.
    rows_pad   = {1'b0, rows_q} + (LINE_W+1)'({ispad_q, 1'b0});
    npass_calc = (rows_pad <= (LINE_W+1)'(2)) ? LINE_W'(1)
                                              : LINE_W'((rows_pad - 1'b1) >> 1);
    grp_last   = (groups_q == '0) ? '0 : groups_q - 1'b1;
    more_pass  = p_q < (npass_q - 1'b1);
    more_grp   = g_q < grp_last;
    ilc_got    = ilc_seen_q | bus.ilc_done;
    wr_got     = wr_seen_q | bus.wr_done;
    load_pass  = ((state_q == S_WLOAD) && bus.wb_rd_ready) ||
                 ((state_q == S_ADV) && more_pass);
    pass_d     = (state_q == S_ADV) ? p_q + 1'b1 : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      linelen_q    <= '0;
      rows_q       <= '0;
      ispad_q      <= 1'b0;
      groups_q     <= '0;
      in_base_q    <= '0;
      out_base_q   <= '0;
      out_stride_q <= '0;
      wb_stride_q  <= '0;
      wb_addr_q    <= '0;
      g_q          <= '0;
      p_q          <= '0;
      npass_q      <= '0;
      calc_p_q     <= 1'b0;
      ilc_seen_q   <= 1'b0;
      wr_seen_q    <= 1'b0;
      wb_rd_conf_q <= 1'b0;
      ilc_start_q  <= 1'b0;
      wr_conf_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wb_rd_conf_q <= 1'b0;
      ilc_start_q  <= 1'b0;
      wr_conf_q    <= 1'b0;
      done_q       <= 1'b0;
      if (calc_p_q) begin
        npass_q  <= npass_calc;
        calc_p_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: if (bus.start) begin
          linelen_q    <= bus.cfg_linelen;
          rows_q       <= bus.cfg_rows;
          ispad_q      <= bus.cfg_ispad;
          groups_q     <= bus.cfg_groups;
          in_base_q    <= bus.cfg_in_base;
          out_base_q   <= bus.cfg_out_base;
          out_stride_q <= bus.cfg_out_stride;
          wb_stride_q  <= bus.cfg_wb_stride;
          wb_addr_q    <= bus.cfg_wb_base;
          g_q          <= '0;
          p_q          <= '0;
          calc_p_q     <= 1'b1;
          wb_rd_conf_q <= 1'b1;
          busy_q       <= 1'b1;
          state_q      <= S_WLOAD;
        end
        S_WLOAD: if (bus.wb_rd_ready) begin
          ilc_start_q <= 1'b1;
          wr_conf_q   <= 1'b1;
          state_q     <= S_PASS;
        end
        S_PASS: begin
          ilc_seen_q <= 1'b0;
          wr_seen_q  <= 1'b0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          ilc_seen_q <= ilc_got;
          wr_seen_q  <= wr_got;
          if (ilc_got && wr_got) state_q <= S_ADV;
        end
        S_ADV: begin
          if (more_pass) begin
            p_q         <= p_q + 1'b1;
            ilc_start_q <= 1'b1;
            wr_conf_q   <= 1'b1;
            state_q     <= S_PASS;
          end else if (more_grp) begin
            // Next weight set only after the last pass of this group is written.
            g_q          <= g_q + 1'b1;
            p_q          <= '0;
            wb_addr_q    <= wb_addr_q + wb_stride_q;
            wb_rd_conf_q <= 1'b1;
            state_q      <= S_WLOAD;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  wsq_pass_addr_gen #(
    .ADDR_LEN (ADDR_LEN),
    .LINE_W   (LINE_W),
    .GRP_W    (GRP_W)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load_pass),
    .pass_i        (pass_d),
    .grp_i         (g_q),
    .npass_i       (npass_q),
    .rows_i        (rows_q),
    .ispad_i       (ispad_q),
    .linelen_i     (linelen_q),
    .in_base_i     (in_base_q),
    .out_base_i    (out_base_q),
    .out_stride_i  (out_stride_q),
    .ilc_st_addr_o (bus.ilc_st_addr),
    .buffermux_o   (bus.buffermux),
    .iszero_o      (bus.iszero),
    .wr_st_addr_o  (bus.wr_st_addr)
  );

  assign bus.wb_rd_conf    = wb_rd_conf_q;
  assign bus.wb_st_rd_addr = wb_addr_q;
  assign bus.ilc_start     = ilc_start_q;
  assign bus.wr_conf       = wr_conf_q;
  assign bus.ispad         = ispad_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_winograd_layer_sequencer.sv
// Directed bench for winograd_layer_sequencer with hand-computed expectations.
module tb_winograd_layer_sequencer;

  localparam int ADDR_LEN = 9;
  localparam int LINE_W   = 10;
  localparam int GRP_W    = 8;
  // Output base 1000 does not fit a 9-bit address; the port keeps 1000 mod 512.
  localparam int OUT_BASE1 = 1000 % (1 << ADDR_LEN);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  winograd_layer_sequencer_if #(.ADDR_LEN(ADDR_LEN), .LINE_W(LINE_W), .GRP_W(GRP_W)) bus ();

  winograd_layer_sequencer #(.ADDR_LEN(ADDR_LEN), .LINE_W(LINE_W), .GRP_W(GRP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int starts      = 0;
  int strays      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sample(input int which);
    bit r;
    case (which)
      0:       r = (bus.ilc_start === 1'b1);
      1:       r = (bus.wb_rd_conf === 1'b1);
      default: r = (bus.done === 1'b1);
    endcase
    return r;
  endfunction

  // which: 0 = ilc_start, 1 = wb_rd_conf, 2 = done. Current cycle counts.
  task automatic wait_sig(input int which, input int budget, input string tag);
    bit seen;
    seen = sample(which);
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (which != 0 && bus.ilc_start === 1'b1) strays++;
      seen = sample(which);
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic set_cfg(input int linelen, input int rows, input int pad, input int groups,
                         input int in_base, input int out_base, input int out_stride,
                         input int wb_base, input int wb_stride);
    bus.cfg_linelen    = LINE_W'(linelen);
    bus.cfg_rows       = LINE_W'(rows);
    bus.cfg_ispad      = 1'(pad);
    bus.cfg_groups     = GRP_W'(groups);
    bus.cfg_in_base    = ADDR_LEN'(in_base);
    bus.cfg_out_base   = ADDR_LEN'(out_base);
    bus.cfg_out_stride = ADDR_LEN'(out_stride);
    bus.cfg_wb_base    = ADDR_LEN'(wb_base);
    bus.cfg_wb_stride  = ADDR_LEN'(wb_stride);
  endtask

  // Waits for a pass to start, checks its registered outputs, then (optionally)
  // returns ilc_done/wr_done after the given delays measured from the first WAIT cycle.
  task automatic run_pass(input string tag, input int mux, input int zero, input int ilc,
                          input int wr, input bit deliver, input int ilc_dly, input int wr_dly);
    bit early;
    int last;
    wait_sig(0, 12, {tag, "_ilc_start"});
    if (bus.ilc_start === 1'b1) starts++;
    chk({tag, "_wr_conf"},     32'(bus.wr_conf), 1);
    chk({tag, "_buffermux"},   32'(bus.buffermux), mux);
    chk({tag, "_iszero"},      32'(bus.iszero), zero);
    chk({tag, "_ilc_st_addr"}, 32'(bus.ilc_st_addr), ilc);
    chk({tag, "_wr_st_addr"},  32'(bus.wr_st_addr), wr);
    tick();
    if (deliver) begin
      early = 1'b0;
      last  = (ilc_dly > wr_dly) ? ilc_dly : wr_dly;
      for (int t = 0; t <= last; t++) begin
        if (bus.ilc_start === 1'b1 || bus.wb_rd_conf === 1'b1 || bus.done === 1'b1) early = 1'b1;
        bus.ilc_done = (t == ilc_dly);
        bus.wr_done  = (t == wr_dly);
        tick();
      end
      bus.ilc_done = 1'b0;
      bus.wr_done  = 1'b0;
      chk({tag, "_no_early_advance"}, 32'(early), 0);
    end
  endtask

  initial begin
    bit bad;
    bus.start = 1'b0;
    bus.wb_rd_ready = 1'b0;
    bus.ilc_done = 1'b0;
    bus.wr_done = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy",        32'(bus.busy), 0);
    chk("rst_done",        32'(bus.done), 0);
    chk("rst_buffermux",   32'(bus.buffermux), 'hE4);
    chk("rst_iszero",      32'(bus.iszero), 0);
    chk("rst_wb_rd_conf",  32'(bus.wb_rd_conf), 0);
    chk("rst_ilc_start",   32'(bus.ilc_start), 0);
    chk("rst_wr_conf",     32'(bus.wr_conf), 0);
    chk("rst_ispad",       32'(bus.ispad), 0);
    chk("rst_wr_st_addr",  32'(bus.wr_st_addr), 0);
    rst_n = 1'b1;
    tick();

    // H=4 padded, one group: P=2; weights held back for 20 cycles
    set_cfg(66, 4, 1, 1, 0, OUT_BASE1, 16, 0, 0);
    starts = 0; strays = 0;
    pulse_start();
    chk("t1_wb_rd_conf",    32'(bus.wb_rd_conf), 1);
    chk("t1_wb_st_rd_addr", 32'(bus.wb_st_rd_addr), 0);
    chk("t1_busy",          32'(bus.busy), 1);
    chk("t1_ispad",         32'(bus.ispad), 1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ilc_start !== 1'b0 || bus.busy !== 1'b1 || bus.wb_rd_conf !== 1'b0) bad = 1'b1;
    end
    chk("t1_hold_no_start", 32'(bad), 0);
    bus.wb_rd_ready = 1'b1;
    tick();
    chk("t1_start_after_ready", 32'(bus.ilc_start), 1);
    run_pass("t1p0", 'hE4, 'b0001, 0, OUT_BASE1,      1'b1, 5, 0);
    run_pass("t1p1", 'h4E, 'b1000, 0, OUT_BASE1 + 16, 1'b1, 0, 0);
    wait_sig(2, 4, "t1_done");
    tick();
    chk("t1_done_one_cycle", 32'(bus.done), 0);
    chk("t1_idle",           32'(bus.busy), 0);
    chk("t1_pass_count",     32'(starts), 2);
    chk("t1_no_stray_start", 32'(strays), 0);

    // H=2 unpadded (P=1), three groups, weight stride 9; ilc_done leads wr_done by 7
    set_cfg(8, 2, 0, 3, 5, 0, 16, 0, 9);
    starts = 0; strays = 0;
    pulse_start();
    for (int g = 0; g < 3; g++) begin
      wait_sig(1, 4, $sformatf("t2g%0d_wb_rd_conf", g));
      chk($sformatf("t2g%0d_wb_st_rd_addr", g), 32'(bus.wb_st_rd_addr), 9 * g);
      run_pass($sformatf("t2g%0d", g), 'hE4, 'b1100, 5, 16 * g, 1'b1, 0, 7);
    end
    wait_sig(2, 4, "t2_done");
    chk("t2_pass_count", 32'(starts), 3);
    tick();

    // H=6 padded (P=3), two groups; reset while waiting on pass 1
    set_cfg(20, 6, 1, 2, 100, 200, 10, 0, 0);
    pulse_start();
    run_pass("t3p0", 'hE4, 'b0001, 100, 200, 1'b1, 0, 0);
    run_pass("t3p1", 'h4E, 'b0000, 100, 210, 1'b0, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t3_rst_busy",        32'(bus.busy), 0);
    chk("t3_rst_buffermux",   32'(bus.buffermux), 'hE4);
    chk("t3_rst_iszero",      32'(bus.iszero), 0);
    chk("t3_rst_ilc_st_addr", 32'(bus.ilc_st_addr), 0);
    chk("t3_rst_wr_st_addr",  32'(bus.wr_st_addr), 0);
    chk("t3_rst_ispad",       32'(bus.ispad), 0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done !== 1'b0) bad = 1'b1;
    end
    chk("t3_no_done_in_reset", 32'(bad), 0);
    rst_n = 1'b1;
    tick();

    // Stray completions in IDLE, then a full layer with a start pulse while busy
    bus.ilc_done = 1'b1;
    bus.wr_done  = 1'b1;
    tick();
    bus.ilc_done = 1'b0;
    bus.wr_done  = 1'b0;
    tick();
    chk("t4_stray_idle", 32'(bus.busy), 0);
    set_cfg(20, 6, 1, 1, 100, 200, 10, 0, 0);
    starts = 0; strays = 0;
    pulse_start();
    set_cfg(20, 2, 0, 5, 300, 0, 1, 0, 0);
    pulse_start();
    run_pass("t4p0", 'hE4, 'b0001, 100, 200, 1'b1, 2, 0);
    run_pass("t4p1", 'h4E, 'b0000, 100, 210, 1'b1, 0, 3);
    run_pass("t4p2", 'hE4, 'b1000, 120, 220, 1'b1, 1, 1);
    wait_sig(2, 4, "t4_done");
    chk("t4_pass_count",     32'(starts), 3);
    chk("t4_no_stray_start", 32'(strays), 0);
    tick();
    chk("t4_idle", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
